prog_loader: RTL and testbench

- Upstream stage of the 8-bit RISC CPU.
- Collects a program image of DEPTH bytes from a valid/ready byte stream, such as a UART receiver or host bridge, into an internal buffer. The stream may stall between bytes.
- Holds the CPU in reset while collecting, then replays the image as one unbroken burst on the CPU's Load/data_in interface (one byte per clock, addresses 0..DEPTH-1).
- Finally releases the CPU to run.

---
 rtl/prog_loader_if.sv | 36 +++
 rtl/prog_loader.sv | 136 +++++++++++++
 tb/tb_prog_loader.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input and CPU load bus of the program loader.
//   start            one-cycle request to load a new image
//   s_valid/s_data   upstream byte stream (valid/ready)
//   s_ready          loader accepts s_data this cycle
//   cpu_rst          active-high reset to the CPU
//   cpu_load         CPU Load strobe
//   cpu_data         CPU data_in byte
//   cpu_addr         index of the byte on cpu_data (debug)
//   busy/done        status: busy in FILL/CLEAR/BURST, done in RUN
//   checksum         XOR of the bytes accepted for the current image
// Modport slave is the loader's view; master is the environment's view.
interface prog_loader_if #(
  parameter int AW = 5
);
  logic          start;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          cpu_rst;
  logic          cpu_load;
  logic [7:0]    cpu_data;
  logic [AW-1:0] cpu_addr;
  logic          busy;
  logic          done;
  logic [7:0]    checksum;

  modport slave (
    input  start, s_valid, s_data,
    output s_ready, cpu_rst, cpu_load, cpu_data, cpu_addr, busy, done, checksum
  );

  modport master (
    output start, s_valid, s_data,
    input  s_ready, cpu_rst, cpu_load, cpu_data, cpu_addr, busy, done, checksum
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: collects a DEPTH-byte program image from a stalling valid/ready
// byte stream while holding the CPU in reset, then replays it as one gap-free
// burst on the CPU Load/data_in bus and releases the CPU.
// Ports:
//   clock  system clock (rising edge)
//   reset  asynchronous active-low reset
//   bus    prog_loader_if.slave (stream in, CPU load bus and status out)
// All outputs are registered.
module prog_loader #(
  parameter int DEPTH      = 32,
  parameter int AW         = 5,
  parameter int CLR_CYCLES = 2
) (
  input  logic         clock,
  input  logic         reset,
  prog_loader_if.slave bus
);
  localparam int            CW       = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_CLR = CW'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_CLEAR, S_BURST, S_RUN} state_t;

  state_t        state_q;
  logic [AW-1:0] idx_q;
  logic [CW-1:0] clr_q;
  logic          s_ready_q;
  logic          cpu_rst_q;
  logic          cpu_load_q;
  logic [7:0]    cpu_data_q;
  logic [AW-1:0] cpu_addr_q;
  logic          busy_q;
  logic          done_q;
  logic [7:0]    checksum_q;

  logic [7:0]    mem_q [DEPTH];
  logic          xfer_d;
  logic [AW-1:0] rd_idx_d;

  // s_ready_q is only ever high in FILL, so this is the accepted-byte strobe.
  assign xfer_d = bus.s_valid && s_ready_q;

  // Read address runs one byte ahead of the burst so the registered read
  // lands on cpu_data exactly in the cycle that byte is due. Outside BURST
  // it points at byte 0, which is what the CLEAR->BURST edge needs.
  assign rd_idx_d = (state_q == S_BURST) ? idx_q + 1'b1 : '0;

  // Image buffer: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clock) begin
    if (xfer_d) begin
      mem_q[idx_q] <= bus.s_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      clr_q      <= '0;
      s_ready_q  <= 1'b0;
      cpu_rst_q  <= 1'b1;
      cpu_load_q <= 1'b0;
      cpu_data_q <= '0;
      cpu_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      checksum_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_RUN: begin
          if (bus.start) begin
            state_q    <= S_FILL;
            idx_q      <= '0;
            checksum_q <= '0;
            s_ready_q  <= 1'b1;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        S_FILL: begin
          if (xfer_d) begin
            checksum_q <= checksum_q ^ bus.s_data;
            if (idx_q == LAST_IDX) begin
              // Drop ready on the same edge as the last transfer so no
              // byte beyond the image can ever be taken.
              state_q   <= S_CLEAR;
              s_ready_q <= 1'b0;
              clr_q     <= '0;
              idx_q     <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_CLEAR: begin
          if (clr_q == LAST_CLR) begin
            state_q    <= S_BURST;
            idx_q      <= '0;
            cpu_rst_q  <= 1'b0;
            cpu_load_q <= 1'b1;
            cpu_data_q <= mem_q[rd_idx_d];
            cpu_addr_q <= '0;
          end else begin
            clr_q <= clr_q + 1'b1;
          end
        end
        S_BURST: begin
          if (idx_q == LAST_IDX) begin
            state_q    <= S_RUN;
            idx_q      <= '0;
            cpu_load_q <= 1'b0;
            cpu_data_q <= '0;
            cpu_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            idx_q      <= idx_q + 1'b1;
            cpu_data_q <= mem_q[rd_idx_d];
            cpu_addr_q <= rd_idx_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.cpu_rst  = cpu_rst_q;
  assign bus.cpu_load = cpu_load_q;
  assign bus.cpu_data = cpu_data_q;
  assign bus.cpu_addr = cpu_addr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.checksum = checksum_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table of load scenarios plus hand-written reset sequences.
// The expected image, checksum and burst timing come from the stimulus itself.
module tb_prog_loader;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int CLR   = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;

  prog_loader_if #(.AW(AW)) bus ();

  prog_loader #(.DEPTH(DEPTH), .AW(AW), .CLR_CYCLES(CLR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string name;
    int    kind;       // 0 ramp, 1 program image, 2 random
    int    max_gap;    // max idle cycles between bytes
    bit    overrun;    // keep offering 0xAA after the last byte
    bit    pulses;     // start pulses during FILL/CLEAR/BURST
    int    exp_rdy;    // expected s_ready-high cycles, -1 = not checked
    int    exp_load;   // expected burst length
    int    exp_clear;  // expected cpu_rst cycles between last byte and burst
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] images [3][DEPTH];
  logic [7:0] prog_img [DEPTH] = '{
    8'hFE, 8'h00, 8'h00, 8'hBA, 8'h12, 8'h34, 8'hC1, 8'h0F,
    8'h80, 8'h7E, 8'h22, 8'h55, 8'hA0, 8'h03, 8'h91, 8'h4C,
    8'h6D, 8'hE8, 8'h17, 8'h29, 8'hB3, 8'h00, 8'h44, 8'h5A,
    8'h0C, 8'hF1, 8'h38, 8'h99, 8'hD7, 8'h61, 8'hE3, 8'h00};

  // Observation record for one load.
  int         cyc = 0;
  logic [7:0] acc_q [$];
  logic [7:0] bd_q  [$];
  int         ba_q  [$];
  int         rdy_cnt, load_cnt, load_rises, rst_in_load, last_tr_cyc, first_ld_cyc;
  logic       prev_load = 1'b0;

  initial begin
    forever begin
      @(negedge clock);
      cyc = cyc + 1;
      if (reset) begin
        if (bus.s_valid && bus.s_ready) begin
          acc_q.push_back(bus.s_data);
          last_tr_cyc = cyc;
        end
        if (bus.s_ready) rdy_cnt = rdy_cnt + 1;
        if (bus.cpu_load) begin
          if (!prev_load) begin
            load_rises = load_rises + 1;
            if (load_rises == 1) first_ld_cyc = cyc;
          end
          load_cnt = load_cnt + 1;
          bd_q.push_back(bus.cpu_data);
          ba_q.push_back(int'(bus.cpu_addr));
          if (bus.cpu_rst) rst_in_load = rst_in_load + 1;
        end
      end
      prev_load = bus.cpu_load;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    acc_q.delete();
    bd_q.delete();
    ba_q.delete();
    rdy_cnt      = 0;
    load_cnt     = 0;
    load_rises   = 0;
    rst_in_load  = 0;
    last_tr_cyc  = 0;
    first_ld_cyc = 0;
  endtask

  function automatic logic [7:0] xor_img(input int kind);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < DEPTH; i++) x = x ^ images[kind][i];
    return x;
  endfunction

  // Pulse start for one cycle; the CPU must be back in reset on that edge.
  task automatic do_start(input string name);
    clear_mon();
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    check({name, ".start_cpu_rst"}, 32'(bus.cpu_rst), 32'd1);
    check({name, ".start_done"},    32'(bus.done),    32'd0);
    check({name, ".start_busy"},    32'(bus.busy),    32'd1);
    check({name, ".start_ready"},   32'(bus.s_ready), 32'd1);
    check({name, ".start_chk"},     32'(bus.checksum), 32'd0);
  endtask

  // Offer the image byte by byte with random gaps; returns after the last
  // transfer edge.
  task automatic feed(input string name, input int kind, input int max_gap, input bit pulses);
    int gap;
    int w;
    bit got;
    for (int i = 0; i < DEPTH; i++) begin
      gap = (max_gap > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'($urandom);
        @(posedge clock); #1;
      end
      bus.s_valid = 1'b1;
      bus.s_data  = images[kind][i];
      bus.start   = pulses && (i == 5 || i == 20);
      got = 1'b0;
      w   = 0;
      while (!got && w < 100) begin
        @(negedge clock);
        got = bus.s_ready;
        @(posedge clock); #1;
        bus.start = 1'b0;
        w++;
      end
      if (!got) begin
        check({name, ".feed_timeout"}, 32'd1, 32'd0);
        bus.s_valid = 1'b0;
        return;
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(input bit overrun, input bit pulses);
    int c;
    c = 0;
    if (overrun) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hAA;
    end
    while (!bus.done && c < 200) begin
      bus.start = pulses && (c == 0 || c == 4);
      @(posedge clock); #1;
      bus.start = 1'b0;
      c++;
    end
    repeat (2) begin
      @(posedge clock); #1;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int dmis;
    int amis;
    do_start(v.name);
    feed(v.name, v.kind, v.max_gap, v.pulses);
    wait_done(v.overrun, v.pulses);
    dmis = 0;
    amis = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k >= bd_q.size()) begin
        dmis++;
        amis++;
      end else begin
        if (bd_q[k] !== images[v.kind][k]) dmis++;
        if (ba_q[k] != k) amis++;
      end
    end
    check({v.name, ".accepted"},  32'(acc_q.size()), 32'(DEPTH));
    check({v.name, ".load_len"},  32'(load_cnt), 32'(v.exp_load));
    check({v.name, ".load_runs"}, 32'(load_rises), 32'd1);
    check({v.name, ".data_mis"},  32'(dmis), 32'd0);
    check({v.name, ".addr_mis"},  32'(amis), 32'd0);
    check({v.name, ".clear_len"}, 32'(first_ld_cyc - last_tr_cyc - 1), 32'(v.exp_clear));
    check({v.name, ".rst_in_ld"}, 32'(rst_in_load), 32'd0);
    if (v.exp_rdy >= 0) check({v.name, ".ready_len"}, 32'(rdy_cnt), 32'(v.exp_rdy));
    check({v.name, ".checksum"},  32'(bus.checksum), 32'(xor_img(v.kind)));
    check({v.name, ".done"},      32'(bus.done), 32'd1);
    check({v.name, ".busy"},      32'(bus.busy), 32'd0);
    check({v.name, ".run_rst"},   32'(bus.cpu_rst), 32'd0);
    check({v.name, ".run_load"},  32'(bus.cpu_load), 32'd0);
    check({v.name, ".run_data"},  32'(bus.cpu_data), 32'd0);
    $display("[TB] load %s: %0d bytes, burst %0d cycles, checksum 0x%02h", v.name,
             acc_q.size(), load_cnt, bus.checksum);
  endtask

  initial begin
    int w;
    bus.start   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      images[0][i] = 8'(i);
      images[1][i] = prog_img[i];
      images[2][i] = 8'($urandom);
    end
    vecs[0] = '{"basic",     0, 0,  1'b0, 1'b0, 32, DEPTH, CLR};
    vecs[1] = '{"stalled",   0, 10, 1'b0, 1'b0, -1, DEPTH, CLR};
    vecs[2] = '{"overrun",   0, 0,  1'b1, 1'b0, 32, DEPTH, CLR};
    vecs[3] = '{"ign_start", 0, 3,  1'b0, 1'b1, -1, DEPTH, CLR};
    vecs[4] = '{"reload",    1, 0,  1'b0, 1'b0, 32, DEPTH, CLR};
    vecs[5] = '{"random",    2, 4,  1'b1, 1'b1, -1, DEPTH, CLR};

    // Reset state, sampled while reset is held.
    #12;
    check("rst.cpu_rst",  32'(bus.cpu_rst),  32'd1);
    check("rst.cpu_load", 32'(bus.cpu_load), 32'd0);
    check("rst.cpu_data", 32'(bus.cpu_data), 32'd0);
    check("rst.cpu_addr", 32'(bus.cpu_addr), 32'd0);
    check("rst.s_ready",  32'(bus.s_ready),  32'd0);
    check("rst.busy",     32'(bus.busy),     32'd0);
    check("rst.done",     32'(bus.done),     32'd0);
    check("rst.checksum", 32'(bus.checksum), 32'd0);
    #10 reset = 1'b1;
    @(posedge clock); #1;

    // Stream traffic in IDLE must be ignored.
    clear_mon();
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h5C;
    repeat (3) begin
      @(posedge clock); #1;
    end
    bus.s_valid = 1'b0;
    check("idle.accepted", 32'(acc_q.size()), 32'd0);
    check("idle.s_ready",  32'(bus.s_ready),  32'd0);
    check("idle.cpu_rst",  32'(bus.cpu_rst),  32'd1);

    for (int t = 0; t < 6; t++) run_vec(vecs[t]);

    // Asynchronous reset in the middle of burst cycle 10.
    do_start("areset");
    feed("areset", 2, 0, 1'b0);
    w = 0;
    while (w < 100 && !(bus.cpu_load && bus.cpu_addr == AW'(10))) begin
      @(negedge clock);
      w++;
    end
    check("areset.reached_c10", 32'(w < 100), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("areset.cpu_load", 32'(bus.cpu_load), 32'd0);
    check("areset.cpu_rst",  32'(bus.cpu_rst),  32'd1);
    check("areset.cpu_data", 32'(bus.cpu_data), 32'd0);
    check("areset.busy",     32'(bus.busy),     32'd0);
    $display("[TB] async reset at burst cycle 10: cpu_load=%0d cpu_rst=%0d", bus.cpu_load, bus.cpu_rst);
    @(negedge clock);
    #2 reset = 1'b1;
    clear_mon();
    repeat (40) begin
      @(posedge clock); #1;
    end
    check("areset.no_resume", 32'(load_cnt),    32'd0);
    check("areset.idle_done", 32'(bus.done),    32'd0);
    check("areset.idle_busy", 32'(bus.busy),    32'd0);
    check("areset.idle_rdy",  32'(bus.s_ready), 32'd0);
    check("areset.idle_rst",  32'(bus.cpu_rst), 32'd1);

    // Recovery from IDLE after the aborted burst.
    run_vec(vecs[4]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
